wave_shaper: RTL and testbench
==============================

# wave_shaper

Downstream stage of the synth oscillator. Samples the oscillator's running 16-bit `count` against its `divider` and computes an 8-bit phase, phase = floor(count·256/divider), using a sequential 8-step restoring divider. It then maps the phase to an 8-bit audio sample (square, saw or triangle) and emits the sample at a fixed rate of one every 10 clocks. Its output feeds the PWM/DAC output stage.

## Interface
Parameters: none. Widths are fixed by the oscillator (16-bit) and the DAC (8-bit).

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: voice enable, the same signal that drives the oscillator `en`.
- `mode` in 2: waveform select. 00 square, 01 saw, 10 triangle, 11 mute.
- `count` in 16: oscillator running count (1..divider).
- `divider` in 16: oscillator period setting.
- `sample` out 8: current sample, unsigned, midscale 8'h80.
- `sample_valid` out 1: one-cycle pulse when `sample` updates.
- `busy` out 1: high while a conversion is in flight (state != IDLE).

## Operation
- **FSM states:** IDLE, DIVIDE, OUTPUT.
- **IDLE.** If `en`=1 at an edge:
  - latch `count` → c, `divider` → d, `mode` → m;
  - clear the 4-bit iteration counter and go to DIVIDE.
  - Otherwise stay in IDLE.
- **Special cases**, decided at the latch edge. The divider still runs its 8 cycles as dummy steps.
  - d==0 → phase forced to 0.
  - c>=d → phase forced to 255 (saturate).
  - Otherwise: remainder r (17-bit) = c, quotient q = 0.
- **DIVIDE.** Each cycle:
  - r' = r<<1;
  - if r' >= d, then r = r'−d and shift 1 into q; else r = r' and shift 0 into q.
  - After 8 iterations go to OUTPUT. Since c<d, q ≤ 255 and no overflow is possible.
- **OUTPUT.** Register `sample` = shape(m, phase), pulse `sample_valid`, return to IDLE.
- **Shape functions** (p = phase):
  - square: p<128 → 8'hFF, else 8'h00.
  - saw: p.
  - triangle: {p[6:0],0}, bit-inverted when p[7]=1.
  - mute: 8'h80.
- **`en` deasserted in DIVIDE or OUTPUT:**
  - abort at that edge and go to IDLE;
  - `sample` ← 8'h80, no `sample_valid` pulse.
- **`en` low in IDLE:** `sample` is held at 8'h80.
- **Input changes after the latch edge:** `count`/`divider`/`mode` changes have no effect on the conversion in flight.

## Timing
- **Reset values:** state IDLE, `sample`=8'h80, `sample_valid`=0, `busy`=0, all internal registers 0.
- **Latch and conversion latency:**
  - latch at edge L;
  - divide steps at edges L+1..L+8;
  - `sample`/`sample_valid` update at L+9, with `sample_valid` high for exactly the cycle after L+9.
- **Sample period:** with `en` held high the next latch is at L+10, giving a fixed period of 10 clocks. The dummy-step rule for special cases keeps the rate uniform.
- **`busy`:** high from the cycle after L through the cycle after L+8.
- **Reset asserted at any time:** immediate return to reset values. No partial sample escapes.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `synth_pkg`:**
  - `wave_mode_t` enum (SQUARE, SAW, TRI, MUTE);
  - `shaper_state_t` enum;
  - `SAMPLE_MID` = 8'h80;
  - `DIV_STEPS` = 8.
- **Sub-module `wave_map`:** purely combinational; (mode, phase) → sample. It is reused later by the LFO path.
- The divider datapath and FSM stay in `wave_shaper`.

## Test plan
- **Reset and idle:**
  - Stimulus: reset, then `en`=0 for 20 cycles.
  - Required: `sample`=8'h80, `sample_valid` never pulses, `busy`=0.
- **Saw and triangle at mid-period:**
  - Stimulus: `divider`=1000, `count`=500, mode saw.
  - Required: `sample`=8'h80 exactly 9 edges after the latch. With mode triangle, same inputs → 8'hFF.
- **Quarter period:**
  - Stimulus: `divider`=1000, `count`=250.
  - Required: saw → 8'h40, square → 8'hFF, triangle → 8'h80.
- **Boundaries:**
  - `count`=`divider`=1000 → phase 255 (saw 8'hFF, square 8'h00).
  - `divider`=0 → saw 8'h00.
  - Both cases keep the 10-cycle period.
- **Continuous run:**
  - Stimulus: hold `en`=1 with a live oscillator model, `divider`=40, for 200 cycles.
  - Required: `sample_valid` pulses every 10 cycles and saw values match floor(c·256/d) for the latched c.
- **Abort and reset mid-operation:**
  - Drop `en` at DIVIDE step 4 → IDLE next edge, `sample`=8'h80, no pulse.
  - Assert `rst` mid-DIVIDE → all outputs at reset values immediately.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the synth voice datapath
package synth_pkg;

  typedef enum logic [1:0] {
    SQUARE = 2'b00,
    SAW    = 2'b01,
    TRI    = 2'b10,
    MUTE   = 2'b11
  } wave_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIVIDE = 2'b01,
    OUTPUT = 2'b10
  } shaper_state_t;

  localparam logic [7:0] SAMPLE_MID = 8'h80;
  localparam int         DIV_STEPS  = 8;

endpackage

// File: rtl/wave_shaper_if.sv
// rtl/wave_shaper_if.sv - oscillator-side inputs and DAC-side sample outputs of the wave shaper
interface wave_shaper_if;

  logic        en;
  logic [1:0]  mode;
  logic [15:0] count;
  logic [15:0] divider;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        busy;

  modport master (
    output en, mode, count, divider,
    input  sample, sample_valid, busy
  );

  modport slave (
    input  en, mode, count, divider,
    output sample, sample_valid, busy
  );

endinterface

// File: rtl/wave_map.sv
// rtl/wave_map.sv - combinational phase-to-sample waveform map, shared with the LFO path
module wave_map
  import synth_pkg::*;
(
  input  wave_mode_t  mode,
  input  logic [7:0]  phase,
  output logic [7:0]  sample
);

  always_comb begin
    sample = SAMPLE_MID;
    unique case (mode)
      SQUARE:  sample = phase[7] ? 8'h00 : 8'hFF;
      SAW:     sample = phase;
      // Ramp up over the first half, mirrored ramp down over the second half.
      TRI:     sample = {phase[6:0], 1'b0} ^ {8{phase[7]}};
      MUTE:    sample = SAMPLE_MID;
      default: sample = SAMPLE_MID;
    endcase
  end

endmodule

// File: rtl/wave_shaper.sv
// rtl/wave_shaper.sv - samples the oscillator count, divides it into an 8-bit phase, shapes one sample every 10 clocks
module wave_shaper
  import synth_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  wave_shaper_if.slave   bus
);

  shaper_state_t state_q, state_d;
  logic [15:0]   d_q, d_d;
  wave_mode_t    m_q, m_d;
  logic [15:0]   r_q, r_d;
  logic [7:0]    q_q, q_d;
  logic [3:0]    iter_q, iter_d;
  logic          fixed_q, fixed_d;
  logic [7:0]    sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

  logic [16:0]   r_shift;
  logic [7:0]    shaped;

  wave_map u_map (
    .mode   (m_q),
    .phase  (q_q),
    .sample (shaped)
  );

  // The remainder always stays below d, so its doubled value fits in 17 bits.
  assign r_shift = {r_q, 1'b0};

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    m_d      = m_q;
    r_d      = r_q;
    q_d      = q_q;
    iter_d   = iter_q;
    fixed_d  = fixed_q;
    sample_d = sample_q;
    valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          d_d     = bus.divider;
          m_d     = wave_mode_t'(bus.mode);
          iter_d  = 4'd0;
          state_d = DIVIDE;
          if (bus.divider == 16'd0) begin
            fixed_d = 1'b1;
            q_d     = 8'd0;
            r_d     = 16'd0;
          end else if (bus.count >= bus.divider) begin
            fixed_d = 1'b1;
            q_d     = 8'hFF;
            r_d     = 16'd0;
          end else begin
            fixed_d = 1'b0;
            q_d     = 8'd0;
            r_d     = bus.count;
          end
        end else begin
          sample_d = SAMPLE_MID;
        end
      end

      DIVIDE: begin
        if (!bus.en) begin
          state_d  = IDLE;
          sample_d = SAMPLE_MID;
        end else begin
          iter_d = iter_q + 4'd1;
          // Forced phases still spend the full step count so the sample rate stays fixed.
          if (!fixed_q) begin
            if (r_shift >= {1'b0, d_q}) begin
              r_d = 16'(r_shift - {1'b0, d_q});
              q_d = {q_q[6:0], 1'b1};
            end else begin
              r_d = r_shift[15:0];
              q_d = {q_q[6:0], 1'b0};
            end
          end
          if (iter_q == 4'(DIV_STEPS - 1)) begin
            state_d = OUTPUT;
          end
        end
      end

      OUTPUT: begin
        state_d = IDLE;
        if (!bus.en) begin
          sample_d = SAMPLE_MID;
        end else begin
          sample_d = shaped;
          valid_d  = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        sample_d = SAMPLE_MID;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      d_q      <= 16'd0;
      m_q      <= SQUARE;
      r_q      <= 16'd0;
      q_q      <= 8'd0;
      iter_q   <= 4'd0;
      fixed_q  <= 1'b0;
      sample_q <= SAMPLE_MID;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      m_q      <= m_d;
      r_q      <= r_d;
      q_q      <= q_d;
      iter_q   <= iter_d;
      fixed_q  <= fixed_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_wave_shaper.sv
// tb/tb_wave_shaper.sv - scoreboard bench for wave_shaper against an arithmetic reference model
module tb_wave_shaper;
  import synth_pkg::*;

  typedef struct {
    logic [7:0] s;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   next_latch = 0;
  bit   osc_on = 1'b0;
  bit   rand_on = 1'b0;
  exp_t exp_q[$];

  wave_shaper_if bus ();

  wave_shaper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_sample(int c, int d, int m);
    int p;
    int s;
    if (d == 0)       p = 0;
    else if (c >= d)  p = 255;
    else              p = (c * 256) / d;
    case (m)
      0:       s = (p < 128) ? 255 : 0;
      1:       s = p;
      2:       s = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: s = 128;
    endcase
    return 8'(s);
  endfunction

  task automatic chk(string nm, int act, int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sample_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sample_value", int'(bus.sample), int'(e.s));
          chk("sample_timing", cyc, e.due);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("missing_valid", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    if (osc_on) bus.count = (bus.count >= bus.divider) ? 16'd1 : bus.count + 16'd1;
    if (rand_on) begin
      bus.count   = 16'($urandom_range(0, 300));
      bus.divider = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      bus.mode    = 2'($urandom_range(0, 3));
    end
    if (bus.en && (cyc + 1 == next_latch)) begin
      exp_t e;
      e.s = ref_sample(int'(bus.count), int'(bus.divider), int'(bus.mode));
      e.due = cyc + 1 + 9;
      exp_q.push_back(e);
      next_latch += 10;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic convert(int c, int d, int m, bit keep);
    bus.count   = 16'(c);
    bus.divider = 16'(d);
    bus.mode    = 2'(m);
    if (!bus.en) begin
      bus.en = 1'b1;
      next_latch = cyc + 1;
    end
    tick();
    bus.count   = 16'($urandom);
    bus.divider = 16'($urandom);
    bus.mode    = 2'($urandom);
    repeat (9) tick();
    if (!keep) begin
      bus.en = 1'b0;
      tick();
      chk("idle_after_conv", int'(bus.sample), 8'h80);
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.mode = 2'd0;
    bus.count = 16'd0;
    bus.divider = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_sample", int'(bus.sample), 8'h80);
    chk("reset_valid", int'(bus.sample_valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_sample", int'(bus.sample), 8'h80);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_valid", int'(bus.sample_valid), 0);
    end

    convert(500, 1000, 1, 1'b0);
    convert(500, 1000, 2, 1'b0);
    convert(250, 1000, 1, 1'b0);
    convert(250, 1000, 0, 1'b0);
    convert(250, 1000, 2, 1'b0);
    convert(1000, 1000, 1, 1'b1);
    convert(1000, 1000, 0, 1'b1);
    convert(5, 0, 1, 1'b1);
    convert(999, 1000, 3, 1'b0);

    // Abort at DIVIDE step 4.
    bus.count = 16'd300; bus.divider = 16'd1000; bus.mode = 2'd1;
    bus.en = 1'b1; next_latch = cyc + 1;
    repeat (5) tick();
    chk("busy_in_divide", int'(bus.busy), 1);
    bus.en = 1'b0;
    exp_q.delete();
    tick();
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_sample", int'(bus.sample), 8'h80);
    chk("abort_valid", int'(bus.sample_valid), 0);
    repeat (12) tick();

    // Asynchronous reset mid-DIVIDE.
    convert(700, 1000, 1, 1'b0);
    bus.count = 16'd300; bus.divider = 16'd1000; bus.mode = 2'd1;
    bus.en = 1'b1; next_latch = cyc + 1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.sample_valid), 0);
    chk("rst_sample", int'(bus.sample), 8'h80);
    exp_q.delete();
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) tick();

    // Continuous run against a live oscillator.
    bus.divider = 16'd40; bus.count = 16'd1; bus.mode = 2'd1;
    osc_on = 1'b1;
    bus.en = 1'b1; next_latch = cyc + 1;
    repeat (200) tick();
    for (int i = 0; i < 12 && (cyc + 1 != next_latch); i++) tick();
    bus.en = 1'b0;
    tick();
    osc_on = 1'b0;

    // Random inputs changing every cycle, all modes and edge cases.
    rand_on = 1'b1;
    bus.en = 1'b1; next_latch = cyc + 1;
    repeat (300) tick();
    for (int i = 0; i < 12 && (cyc + 1 != next_latch); i++) tick();
    bus.en = 1'b0;
    rand_on = 1'b0;
    tick();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
